// File: rtl/alu_exec.sv
// Execute-stage ALU for the multicycle RV32I core.
// Logic and add/sub ops finish one cycle after capture. Shifts move one bit
// per cycle. Result and compare flags are registered and held until the
// next operation updates them.
module alu_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_en,
  input  logic [WIDTH-28:0] alu_op,
  input  logic [WIDTH-1:0]  port_a,
  input  logic [WIDTH-1:0]  port_b,
  output logic [WIDTH-1:0]  alu_result,
  output logic              alu_valid,
  output logic              flag_eq,
  output logic              flag_lt,
  output logic              flag_ltu,
  output logic              alu_busy
);

  localparam int OP_W = WIDTH - 27;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(5'b01101);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(5'b01110);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(5'b10000);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_EXEC     = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_WAIT_LOW = 3'd4;

  logic [2:0]         state_q,  state_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [WIDTH-1:0]   b_q,      b_d;
  logic [OP_W-1:0]    op_q,     op_d;
  logic [WIDTH-1:0]   work_q,   work_d;
  logic [SHAMT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q,  valid_d;
  logic               eq_q,     eq_d;
  logic               lt_q,     lt_d;
  logic               ltu_q,    ltu_d;

  // Single-position shifts of the working register, one per shift kind.
  logic [WIDTH-1:0] sll_w;
  logic [WIDTH-1:0] srl_w;
  logic [WIDTH-1:0] sra_w;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift1
      if (gi == 0) begin : g_lsb
        assign sll_w[gi] = 1'b0;
      end else begin : g_upper
        assign sll_w[gi] = work_q[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_msb
        assign srl_w[gi] = 1'b0;
        assign sra_w[gi] = work_q[WIDTH-1];
      end else begin : g_lower
        assign srl_w[gi] = work_q[gi+1];
        assign sra_w[gi] = work_q[gi+1];
      end
    end
  endgenerate

  logic             new_is_shift;
  logic [WIDTH-1:0] shift1_val;
  logic [WIDTH-1:0] exec_val;

  // Decode whether the incoming op is a shift, used only at capture.
  always_comb begin
    new_is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
  end

  // Pick the one-bit shift matching the captured op.
  always_comb begin
    shift1_val = srl_w;
    if (op_q == OP_SLL) begin
      shift1_val = sll_w;
    end else if (op_q == OP_SRA) begin
      shift1_val = sra_w;
    end
  end

  // Single-cycle result; shifts only reach here with a zero amount.
  always_comb begin
    exec_val = '0;
    case (op_q)
      OP_ADD:                 exec_val = a_q + b_q;
      OP_SUB:                 exec_val = a_q - b_q;
      OP_AND:                 exec_val = a_q & b_q;
      OP_OR:                  exec_val = a_q | b_q;
      OP_XOR:                 exec_val = a_q ^ b_q;
      OP_SLL, OP_SRL, OP_SRA: exec_val = a_q;
      default:                exec_val = '0;
    endcase
  end

  // Next-state logic for the control FSM and the datapath registers.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = valid_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    case (state_q)
      S_IDLE: begin
        if (alu_en) begin
          a_d    = port_a;
          b_d    = port_b;
          op_d   = alu_op;
          work_d = port_a;
          cnt_d  = port_b[SHAMT_W-1:0];
          eq_d   = (port_a == port_b);
          lt_d   = ($signed(port_a) < $signed(port_b));
          ltu_d  = (port_a < port_b);
          if (new_is_shift && (port_b[SHAMT_W-1:0] != '0)) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        result_d = exec_val;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_SHIFT: begin
        work_d = shift1_val;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shift1_val;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        // A request still held from the previous op must not recapture.
        if (!alu_en) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
    end
  end

  assign alu_result = result_q;
  assign alu_valid  = valid_q;
  assign flag_eq    = eq_q;
  assign flag_lt    = lt_q;
  assign flag_ltu   = ltu_q;
  assign alu_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_exec;

  logic        clk;
  logic        rst;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [31:0] alu_result;
  logic        alu_valid;
  logic        flag_eq;
  logic        flag_lt;
  logic        flag_ltu;
  logic        alu_busy;

  int errors;
  int checks;

  alu_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .port_a     (port_a),
    .port_b     (port_b),
    .alu_result (alu_result),
    .alu_valid  (alu_valid),
    .flag_eq    (flag_eq),
    .flag_lt    (flag_lt),
    .flag_ltu   (flag_ltu),
    .alu_busy   (alu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: result straight from the op definitions.
  function automatic logic [31:0] ref_result(input logic [4:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      5'b00000: return a + b;
      5'b00011: return a - b;
      5'b01010: return a & b;
      5'b01100: return a | b;
      5'b01101: return a ^ b;
      5'b01110: return a << sh;
      5'b01111: return a >> sh;
      5'b10000: return 32'($signed(a) >>> sh);
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] b);
    if ((op == 5'b01110 || op == 5'b01111 || op == 5'b10000) && (b % 32) != 0)
      return int'(b % 32);
    return 1;
  endfunction

  // Runs one request through the handshake and reports what was observed.
  // Inputs are scrambled right after capture; alu_en stays high for
  // hold_extra cycles past the DONE cycle before being dropped.
  task automatic issue_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold_extra,
                          output logic [31:0] res, output int lat,
                          output int pulses, output logic [2:0] flags,
                          output logic idle_after);
    res = 'x; flags = 'x; lat = -1; pulses = 0;
    @(posedge clk); #1;
    alu_en = 1'b1; alu_op = op; port_a = a; port_b = b;
    @(posedge clk); #1;
    port_a = $urandom; port_b = $urandom; alu_op = 5'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (alu_valid) begin
        lat = c - 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (alu_valid) begin
      if (lat < 0) lat = 40;
      res = alu_result;
      flags = {flag_eq, flag_lt, flag_ltu};
      pulses = 1;
      for (int k = 0; k <= hold_extra; k++) begin
        @(posedge clk); #1;
        if (alu_valid) pulses++;
      end
    end
    alu_en = 1'b0;
    @(posedge clk); #1;
    idle_after = ~alu_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_en = 1'b0; alu_op = '0; port_a = '0; port_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", alu_valid); end
    checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", alu_result); end
    checks++; if (alu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", alu_busy); end
    checks++; if ({flag_eq, flag_lt, flag_ltu} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {flag_eq, flag_lt, flag_ltu}); end
    $display("reset: valid=%b result=%h busy=%b", alu_valid, alu_result, alu_busy);
  endtask

  task automatic test_add();
    logic [31:0] r; int lat, pl; logic [2:0] f; logic idle;
    issue_op(5'b00000, 32'hFFFFFFFF, 32'h1, 0, r, lat, pl, f, idle);
    $display("add: a=ffffffff b=1 res=%h lat=%0d pulses=%0d flags=%b", r, lat, pl, f);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL add_result got=%h exp=00000000", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (pl !== 1) begin errors++; $display("FAIL add_pulse got=%0d exp=1", pl); end
    checks++; if (f[0] !== 1'b0) begin errors++; $display("FAIL add_ltu got=%b exp=0", f[0]); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL add_idle got=%b exp=1", idle); end
  endtask

  task automatic test_sub();
    logic [31:0] r; int lat, pl; logic [2:0] f; logic idle;
    issue_op(5'b00011, 32'd5, 32'd7, 0, r, lat, pl, f, idle);
    $display("sub: a=5 b=7 res=%h lat=%0d flags=%b", r, lat, f);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result got=%h exp=fffffffe", r); end
    checks++; if (f !== 3'b011) begin errors++; $display("FAIL sub_flags got=%b exp=011", f); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL sub_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_shift();
    logic [31:0] r; int lat, pl; logic [2:0] f; logic idle;
    issue_op(5'b10000, 32'h80000000, 32'd4, 0, r, lat, pl, f, idle);
    $display("sra: a=80000000 b=4 res=%h lat=%0d", r, lat);
    checks++; if (r !== 32'hF8000000) begin errors++; $display("FAIL sra_result got=%h exp=f8000000", r); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL sra_latency got=%0d exp=4", lat); end
    checks++; if (pl !== 1) begin errors++; $display("FAIL sra_pulse got=%0d exp=1", pl); end
    issue_op(5'b01111, 32'h80000000, 32'd4, 0, r, lat, pl, f, idle);
    $display("srl: a=80000000 b=4 res=%h lat=%0d", r, lat);
    checks++; if (r !== 32'h08000000) begin errors++; $display("FAIL srl_result got=%h exp=08000000", r); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL srl_latency got=%0d exp=4", lat); end
    issue_op(5'b01110, 32'h00000001, 32'd31, 0, r, lat, pl, f, idle);
    $display("sll: a=1 b=31 res=%h lat=%0d", r, lat);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL sll31_result got=%h exp=80000000", r); end
    checks++; if (lat !== 31) begin errors++; $display("FAIL sll31_latency got=%0d exp=31", lat); end
    issue_op(5'b10000, 32'h9ABCDEF0, 32'h00000020, 0, r, lat, pl, f, idle);
    $display("sra0: a=9abcdef0 b=20 res=%h lat=%0d", r, lat);
    checks++; if (r !== 32'h9ABCDEF0) begin errors++; $display("FAIL sra0_result got=%h exp=9abcdef0", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL sra0_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_handshake();
    logic [31:0] r; int lat, pl; logic [2:0] f; logic idle;
    issue_op(5'b01101, 32'h12345678, 32'h0F0F0F0F, 3, r, lat, pl, f, idle);
    $display("hold: xor res=%h pulses=%0d idle=%b", r, pl, idle);
    checks++; if (pl !== 1) begin errors++; $display("FAIL hold_pulses got=%0d exp=1", pl); end
    checks++; if (r !== 32'h1D3B5977) begin errors++; $display("FAIL hold_result got=%h exp=1d3b5977", r); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL hold_idle got=%b exp=1", idle); end
    issue_op(5'b01010, 32'h0000F0F0, 32'h0000FF00, 0, r, lat, pl, f, idle);
    $display("and: a=f0f0 b=ff00 res=%h lat=%0d", r, lat);
    checks++; if (r !== 32'h0000F000) begin errors++; $display("FAIL and_result got=%h exp=0000f000", r); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r; int lat, pl; logic [2:0] f; logic idle;
    int seen;
    @(posedge clk); #1;
    alu_en = 1'b1; alu_op = 5'b01110; port_a = 32'hDEADBEEF; port_b = 32'd20;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    checks++; if (alu_busy !== 1'b1) begin errors++; $display("FAIL midshift_busy got=%b exp=1", alu_busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; alu_en = 1'b0;
    checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL rstshift_result got=%h exp=0", alu_result); end
    checks++; if (alu_busy !== 1'b0) begin errors++; $display("FAIL rstshift_busy got=%b exp=0", alu_busy); end
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (alu_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstshift_novalid got=%0d exp=0", seen); end
    $display("reset mid-shift: result=%h busy=%b valids=%0d", alu_result, alu_busy, seen);
    issue_op(5'b00000, 32'd100, 32'd23, 0, r, lat, pl, f, idle);
    $display("post-reset add: res=%h lat=%0d", r, lat);
    checks++; if (r !== 32'd123) begin errors++; $display("FAIL postrst_result got=%h exp=%h", r, 32'd123); end
  endtask

  task automatic test_random();
    logic [4:0] ops [9];
    logic [31:0] r, a, b, er; int lat, pl, el; logic [2:0] f, ef; logic idle;
    logic [4:0] op;
    ops = '{5'b00000, 5'b00011, 5'b01010, 5'b01100, 5'b01101,
            5'b01110, 5'b01111, 5'b10000, 5'b00001};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 8)];
      if (i % 9 == 8) op = 5'($urandom);
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      if (i % 5 == 0) b = {a[31:5], b[4:0]};
      er = ref_result(op, a, b);
      el = ref_latency(op, b);
      ef = {a == b, $signed(a) < $signed(b), a < b};
      issue_op(op, a, b, i % 3, r, lat, pl, f, idle);
      $display("rand %0d: op=%b a=%h b=%h res=%h exp=%h lat=%0d exp=%0d", i, op, a, b, r, er, lat, el);
      checks++; if (r !== er) begin errors++; $display("FAIL rand_result[%0d] got=%h exp=%h", i, r, er); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, el); end
      checks++; if (f !== ef) begin errors++; $display("FAIL rand_flags[%0d] got=%b exp=%b", i, f, ef); end
      checks++; if (pl !== 1) begin errors++; $display("FAIL rand_pulse[%0d] got=%0d exp=1", i, pl); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_handshake();
    test_reset_mid_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
